// File: rtl/fanout_capture_pkg.sv
// Shared types and helpers for the fanout capture/vote sink.
// Defaults mirror the top-level parameter defaults; instances derive their own sizes.
package fanout_capture_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FAULT = 2'd2
   } state_t;

   localparam int LANES_DEF = 6;
   localparam int CNT_W_DEF = 8;
   localparam int MAX_LANES = 64;
   localparam int HALF      = LANES_DEF / 2;
   localparam int CNT_MAX   = (1 << CNT_W_DEF) - 1;

   function automatic int unsigned popcount(input logic [MAX_LANES-1:0] v);
      int unsigned n;
      n = 0;
      for (int i = 0; i < MAX_LANES; i++) n = n + 32'(v[i]);
      return n;
   endfunction

endpackage

// File: rtl/fanout_sync_fifo.sv
// 1-bit synchronous FIFO; a push into a full FIFO only lands if a pop frees a slot that cycle.
module fanout_sync_fifo
   import fanout_capture_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_push,
   input  logic i_din,
   input  logic i_pop,
   output logic o_dout,
   output logic o_full,
   output logic o_empty,
   output logic o_drop
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [DEPTH-1:0] r_mem;
   logic [AW-1:0]    r_rd;
   logic [AW-1:0]    r_wr;
   logic [CW-1:0]    r_cnt;
   logic             r_last;
   logic             w_pop_ok;
   logic             w_push_ok;

   assign o_full    = (r_cnt == CW'(DEPTH));
   assign o_empty   = (r_cnt == '0);
   assign w_pop_ok  = i_pop && !o_empty;
   assign w_push_ok = i_push && (!o_full || w_pop_ok);
   assign o_drop    = i_push && !w_push_ok;
   // When empty, keep presenting the last bit handed to the consumer.
   assign o_dout    = o_empty ? r_last : r_mem[r_rd];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mem  <= '0;
         r_rd   <= '0;
         r_wr   <= '0;
         r_cnt  <= '0;
         r_last <= 1'b0;
      end else begin
         if (w_push_ok) begin
            r_mem[r_wr] <= i_din;
            r_wr        <= r_wr + 1'b1;
         end
         if (w_pop_ok) begin
            r_last <= r_mem[r_rd];
            r_rd   <= r_rd + 1'b1;
         end
         r_cnt <= r_cnt + CW'(w_push_ok) - CW'(w_pop_ok);
      end
   end

endmodule

// File: rtl/fanout_capture_voter.sv
// Captures LANES replicated copies of one driver bit, majority-votes them, counts
// lane disagreements into a fault state and queues voted bits behind valid/ready.
module fanout_capture_voter
   import fanout_capture_pkg::*;
#(
   parameter int LANES      = LANES_DEF,
   parameter int DEPTH      = 4,
   parameter int CNT_W      = CNT_W_DEF,
   parameter int ERR_THRESH = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_en,
   input  logic [LANES-1:0] i_lanes_in,
   input  logic             i_clr_err,
   output logic             o_out_valid,
   input  logic             i_out_ready,
   output logic             o_out_data,
   output logic [CNT_W-1:0] o_mismatch_cnt,
   output logic             o_fault,
   output logic             o_ovf_sticky
);

   localparam int unsigned      L_HALF    = LANES / 2;
   localparam int unsigned      L_LANES   = LANES;
   localparam logic [CNT_W-1:0] L_CNT_MAX = '1;
   localparam logic [CNT_W-1:0] L_THRESH  = CNT_W'(ERR_THRESH);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [LANES-1:0] r_cap_q;
   logic             r_cap_v;
   logic             r_prev_vote;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_inc;
   logic             r_ovf;
   int unsigned      w_pc;
   logic             w_vote;
   logic             w_mismatch;
   logic             w_inc;
   logic             w_capture;
   logic             w_full;
   logic             w_empty;
   logic             w_drop;

   always_comb begin
      w_pc = popcount(MAX_LANES'(r_cap_q));
      // An exact split can only happen with an even lane count; it keeps the previous decision.
      if ((LANES % 2 == 0) && (w_pc == L_HALF)) w_vote = r_prev_vote;
      else                                     w_vote = (w_pc > L_HALF);
      w_mismatch = r_cap_v && (w_pc != 0) && (w_pc != L_LANES);
      w_inc      = w_mismatch && !i_clr_err;
      w_cnt_inc  = (r_cnt == L_CNT_MAX) ? r_cnt : r_cnt + 1'b1;
      w_capture  = i_en && (r_state != FAULT);
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         IDLE:    if (i_en) w_state_nxt = RUN;
         RUN: begin
            if (w_inc && (w_cnt_inc >= L_THRESH)) w_state_nxt = FAULT;
            else if (!i_en)                      w_state_nxt = IDLE;
         end
         FAULT:   if (i_clr_err) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_cap_q     <= '0;
         r_cap_v     <= 1'b0;
         r_prev_vote <= 1'b0;
         r_cnt       <= '0;
         r_ovf       <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cap_v <= w_capture;
         if (w_capture) r_cap_q <= i_lanes_in;
         if (r_cap_v) r_prev_vote <= w_vote;
         if (i_clr_err)  r_cnt <= '0;
         else if (w_inc) r_cnt <= w_cnt_inc;
         if (i_clr_err)            r_ovf <= 1'b0;
         else if (w_drop && w_full) r_ovf <= 1'b1;
      end
   end

   fanout_sync_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (r_cap_v),
      .i_din   (w_vote),
      .i_pop   (i_out_ready),
      .o_dout  (o_out_data),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_drop  (w_drop)
   );

   assign o_out_valid    = !w_empty;
   assign o_mismatch_cnt = r_cnt;
   assign o_fault        = (r_state == FAULT);
   assign o_ovf_sticky   = r_ovf;

endmodule

// File: tb/tb_fanout_capture_voter.sv
// Scenario bench: a scoreboard queue holds predicted voted bits; drains compare them in order.
module tb_fanout_capture_voter;

   localparam int LN = 6;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic          en1 = 0, clr1 = 0, rdy1 = 0, v1, d1, f1, ovf1;
   logic [LN-1:0] lanes1 = '0;
   logic [7:0]    cnt1;
   logic          en2 = 0, clr2 = 0, rdy2 = 1, v2, d2, f2, ovf2;
   logic [LN-1:0] lanes2 = '0;
   logic [1:0]    cnt2;

   int n_chk  = 0;
   int n_fail = 0;
   bit exp_q[$];
   bit tb_prev = 0;

   fanout_capture_voter #(.LANES(LN), .DEPTH(4), .CNT_W(8), .ERR_THRESH(3)) dut1 (
      .clk(clk), .rst_n(rst_n), .i_en(en1), .i_lanes_in(lanes1), .i_clr_err(clr1),
      .o_out_valid(v1), .i_out_ready(rdy1), .o_out_data(d1), .o_mismatch_cnt(cnt1),
      .o_fault(f1), .o_ovf_sticky(ovf1));

   fanout_capture_voter #(.LANES(LN), .DEPTH(4), .CNT_W(2), .ERR_THRESH(3)) dut2 (
      .clk(clk), .rst_n(rst_n), .i_en(en2), .i_lanes_in(lanes2), .i_clr_err(clr2),
      .o_out_valid(v2), .i_out_ready(rdy2), .o_out_data(d2), .o_mismatch_cnt(cnt2),
      .o_fault(f2), .o_ovf_sticky(ovf2));

   task automatic tick();
      @(posedge clk); #1;
   endtask

   // Predict the vote for a captured sample; push it only if it will land in the FIFO.
   task automatic expect_sample(input logic [LN-1:0] l, input bit pushed);
      int pc;
      bit v;
      pc = $countones(l);
      if (pc > LN / 2)      v = 1'b1;
      else if (pc < LN / 2) v = 1'b0;
      else                  v = tb_prev;
      tb_prev = v;
      if (pushed) exp_q.push_back(v);
   endtask

   task automatic drain(input string tag);
      int k;
      bit e;
      k = 0;
      rdy1 = 1;
      while ((v1 || exp_q.size() != 0) && k < 40) begin
         if (v1) begin
            n_chk++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL %s extra_entry: out_data=%0b, expected no entry", tag, d1);
            end else begin
               e = exp_q.pop_front();
               if (d1 !== e) begin
                  n_fail++;
                  $display("FAIL %s out_data: got %0b, expected %0b", tag, d1, e);
               end
            end
         end
         tick();
         k++;
      end
      rdy1 = 0;
      n_chk++;
      if (k >= 40 || exp_q.size() != 0 || v1 !== 1'b0) begin
         n_fail++;
         $display("FAIL %s drain_end: cycles=%0d left=%0d out_valid=%0b, expected empty", tag, k, exp_q.size(), v1);
      end
      exp_q.delete();
   endtask

   task automatic test_reset();
      rst_n = 0;
      #12;
      n_chk++;
      if ({v1, d1, cnt1, f1, ovf1} !== 12'h0) begin
         n_fail++;
         $display("FAIL reset dut1: got v=%0b d=%0b cnt=%0d f=%0b ovf=%0b, expected all 0", v1, d1, cnt1, f1, ovf1);
      end
      n_chk++;
      if ({v2, d2, cnt2, f2, ovf2} !== 6'h0) begin
         n_fail++;
         $display("FAIL reset dut2: got v=%0b d=%0b cnt=%0d f=%0b ovf=%0b, expected all 0", v2, d2, cnt2, f2, ovf2);
      end
      rst_n = 1;
      tick();
   endtask

   task automatic test_latency();
      en1 = 1; lanes1 = 6'b111111; expect_sample(lanes1, 1);
      tick();
      en1 = 0;
      n_chk++;
      if (v1 !== 1'b0) begin n_fail++; $display("FAIL lat_early out_valid: got %0b, expected 0", v1); end
      tick();
      n_chk++;
      if ({v1, d1} !== 2'b11 || cnt1 !== 8'd0) begin
         n_fail++;
         $display("FAIL lat_out: got v=%0b d=%0b cnt=%0d, expected v=1 d=1 cnt=0", v1, d1, cnt1);
      end
      drain("lat");
   endtask

   task automatic test_tie_vote();
      en1 = 1; lanes1 = 6'b000111; expect_sample(lanes1, 1);
      tick();
      lanes1 = 6'b000010; expect_sample(lanes1, 1);
      tick();
      n_chk++;
      if (cnt1 !== 8'd1) begin n_fail++; $display("FAIL tie_cnt1: got %0d, expected 1", cnt1); end
      lanes1 = 6'b000111; expect_sample(lanes1, 1);
      tick();
      n_chk++;
      if (cnt1 !== 8'd2) begin n_fail++; $display("FAIL tie_cnt2: got %0d, expected 2", cnt1); end
      lanes1 = 6'b111111; expect_sample(lanes1, 1);
      clr1 = 1;
      tick();
      clr1 = 0; en1 = 0;
      n_chk++;
      if (cnt1 !== 8'd0 || f1 !== 1'b0) begin
         n_fail++;
         $display("FAIL clr_priority: got cnt=%0d f=%0b, expected cnt=0 f=0", cnt1, f1);
      end
      tick();
      drain("tie");
   endtask

   task automatic test_fault();
      en1 = 1; lanes1 = 6'b110000;
      for (int i = 0; i < 3; i++) begin
         expect_sample(lanes1, 1);
         tick();
      end
      en1 = 0;
      n_chk++;
      if (f1 !== 1'b0 || cnt1 !== 8'd2) begin
         n_fail++;
         $display("FAIL fault_pre: got f=%0b cnt=%0d, expected f=0 cnt=2", f1, cnt1);
      end
      tick();
      n_chk++;
      if (f1 !== 1'b1 || cnt1 !== 8'd3) begin
         n_fail++;
         $display("FAIL fault_enter: got f=%0b cnt=%0d, expected f=1 cnt=3", f1, cnt1);
      end
      en1 = 1; lanes1 = 6'b111111;
      for (int i = 0; i < 3; i++) tick();
      en1 = 0;
      n_chk++;
      if (f1 !== 1'b1) begin n_fail++; $display("FAIL fault_hold: got f=%0b, expected 1", f1); end
      drain("fault");
      clr1 = 1;
      tick();
      clr1 = 0;
      n_chk++;
      if (f1 !== 1'b0 || cnt1 !== 8'd0) begin
         n_fail++;
         $display("FAIL fault_clr: got f=%0b cnt=%0d, expected f=0 cnt=0", f1, cnt1);
      end
   endtask

   task automatic test_overflow();
      rdy1 = 0;
      for (int i = 0; i < 6; i++) begin
         en1 = 1;
         lanes1 = (i % 2 == 0) ? 6'b111111 : 6'b000000;
         expect_sample(lanes1, i < 4);
         tick();
         if (i == 4) begin
            n_chk++;
            if (ovf1 !== 1'b0) begin n_fail++; $display("FAIL ovf_early: got %0b, expected 0", ovf1); end
         end
         if (i == 5) begin
            n_chk++;
            if (ovf1 !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %0b, expected 1", ovf1); end
         end
      end
      en1 = 0;
      tick();
      drain("ovf");
      clr1 = 1;
      tick();
      clr1 = 0;
      n_chk++;
      if (ovf1 !== 1'b0) begin n_fail++; $display("FAIL ovf_clr: got %0b, expected 0", ovf1); end
   endtask

   task automatic test_full_push_pop();
      logic [LN-1:0] pat [5];
      pat = '{6'b111111, 6'b111111, 6'b000000, 6'b111111, 6'b000000};
      rdy1 = 0;
      for (int i = 0; i < 5; i++) begin
         en1 = 1; lanes1 = pat[i]; expect_sample(lanes1, 1);
         tick();
      end
      en1 = 0;
      rdy1 = 1;
      n_chk++;
      if (d1 !== exp_q[0]) begin n_fail++; $display("FAIL full_head: got %0b, expected %0b", d1, exp_q[0]); end
      void'(exp_q.pop_front());
      tick();
      rdy1 = 0;
      n_chk++;
      if (v1 !== 1'b1 || ovf1 !== 1'b0 || d1 !== exp_q[0]) begin
         n_fail++;
         $display("FAIL full_pushpop: got v=%0b ovf=%0b d=%0b, expected v=1 ovf=0 d=%0b", v1, ovf1, d1, exp_q[0]);
      end
      drain("fullpp");
   endtask

   task automatic test_small_counter();
      logic [LN-1:0] lt [8];
      bit ct [8];
      int ec [8];
      en2 = 1; lanes2 = 6'b110000;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (i == 2) begin
            n_chk++;
            if (cnt2 !== 2'd2 || f2 !== 1'b0) begin
               n_fail++; $display("FAIL sc_pre: got cnt=%0d f=%0b, expected cnt=2 f=0", cnt2, f2);
            end
         end
      end
      en2 = 0;
      n_chk++;
      if (cnt2 !== 2'd3 || f2 !== 1'b1) begin
         n_fail++; $display("FAIL sc_fault: got cnt=%0d f=%0b, expected cnt=3 f=1", cnt2, f2);
      end
      tick();
      n_chk++;
      if (cnt2 !== 2'd3 || f2 !== 1'b1) begin
         n_fail++; $display("FAIL sc_sat: got cnt=%0d f=%0b, expected cnt=3 f=1", cnt2, f2);
      end
      clr2 = 1; tick(); clr2 = 0;
      n_chk++;
      if (cnt2 !== 2'd0 || f2 !== 1'b0) begin
         n_fail++; $display("FAIL sc_clr: got cnt=%0d f=%0b, expected cnt=0 f=0", cnt2, f2);
      end
      lt = '{6'b110000, 6'b110000, 6'b111111, 6'b110000, 6'b110000, 6'b110000, 6'b000000, 6'b000000};
      ct = '{0, 0, 0, 1, 0, 0, 1, 0};
      ec = '{0, 1, 2, 0, 1, 2, 0, 0};
      for (int k = 0; k < 8; k++) begin
         en2 = (k < 7); lanes2 = lt[k]; clr2 = ct[k];
         tick();
         n_chk++;
         if (cnt2 !== 2'(ec[k]) || f2 !== 1'b0) begin
            n_fail++; $display("FAIL sc_row%0d: got cnt=%0d f=%0b, expected cnt=%0d f=0", k, cnt2, f2, ec[k]);
         end
      end
      clr2 = 0; en2 = 0;
   endtask

   task automatic test_async_reset();
      rdy1 = 0; en1 = 1; lanes1 = 6'b111111;
      en2 = 1; lanes2 = 6'b110000;
      for (int i = 0; i < 3; i++) tick();
      n_chk++;
      if (v1 !== 1'b1 || cnt2 !== 2'd2) begin
         n_fail++; $display("FAIL ar_pre: got v1=%0b cnt2=%0d, expected v1=1 cnt2=2", v1, cnt2);
      end
      #3 rst_n = 0;
      #1;
      n_chk++;
      if ({v1, d1, cnt1, f1, ovf1, v2, cnt2, f2} !== 16'h0) begin
         n_fail++;
         $display("FAIL ar_clear: got v1=%0b d1=%0b cnt1=%0d f1=%0b ovf1=%0b v2=%0b cnt2=%0d f2=%0b, expected all 0",
                  v1, d1, cnt1, f1, ovf1, v2, cnt2, f2);
      end
      en1 = 0; en2 = 0;
      exp_q.delete(); tb_prev = 0;
      #2 rst_n = 1;
      tick();
      n_chk++;
      if (v1 !== 1'b0) begin n_fail++; $display("FAIL ar_flush: got out_valid=%0b, expected 0", v1); end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_latency();
      test_tie_vote();
      test_fault();
      test_overflow();
      test_full_push_pop();
      test_small_counter();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
